// File: rtl/norm_round.sv
// Post-add normalize and round-to-nearest-even stage for IEEE-754 adders.
// One transaction at a time: IDLE -> NORM (1+ cycles) -> ROUND -> DONE.
module norm_round #(
  parameter int unsigned N_float = 32,
  parameter int unsigned N_exp   = 8,
  parameter int unsigned N_mant  = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sum_sign,
  input  logic [N_exp-1:0]   sum_exp,
  input  logic [N_mant+4:0]  sum_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_float-1:0] float_R,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned EW = N_exp + 2;
  localparam int unsigned MW = N_mant + 5;
  localparam int unsigned RW = N_mant + 2;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = EW'((2 ** N_exp) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sign, w_sign_nxt;
  logic [EW-1:0]        r_exp, w_exp_nxt;
  logic [MW-1:0]        r_mant, w_mant_nxt;
  logic [N_float-1:0]   r_float, w_float_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic                 r_udf, w_udf_nxt;
  logic                 r_in_ready, r_out_valid;

  logic                 w_rnd_up;
  logic [RW-1:0]        w_rnd_sum;
  logic [EW-1:0]        w_rnd_exp;
  logic [N_mant-1:0]    w_rnd_frac;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign float_R   = r_float;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

  // Round-to-nearest-even on {carry, hidden, fraction}; renormalize a rounding carry.
  always_comb begin
    w_rnd_up  = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    w_rnd_sum = r_mant[MW-1:3] + RW'(w_rnd_up);
    if (w_rnd_sum[RW-1]) begin
      w_rnd_frac = w_rnd_sum[N_mant:1];
      w_rnd_exp  = r_exp + EXP_ONE;
    end else begin
      w_rnd_frac = w_rnd_sum[N_mant-1:0];
      w_rnd_exp  = r_exp;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_mant_nxt  = r_mant;
    w_float_nxt = r_float;
    w_ovf_nxt   = r_ovf;
    w_udf_nxt   = r_udf;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = sum_sign;
          w_exp_nxt   = EW'(sum_exp);
          w_mant_nxt  = sum_mant;
          w_ovf_nxt   = 1'b0;
          w_udf_nxt   = 1'b0;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (r_mant == '0) begin
          w_float_nxt = '0;
          w_state_nxt = DONE;
        end else if (r_mant[MW-1]) begin
          w_mant_nxt  = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
          w_exp_nxt   = r_exp + EXP_ONE;
          w_state_nxt = ROUND;
        end else if (r_mant[MW-2]) begin
          w_state_nxt = ROUND;
        end else if (r_exp <= EXP_ONE) begin
          // Exponent floor reached without a leading one: flush to signed zero.
          w_float_nxt              = '0;
          w_float_nxt[N_float-1]   = r_sign;
          w_udf_nxt                = 1'b1;
          w_state_nxt              = DONE;
        end else begin
          w_mant_nxt = {r_mant[MW-2:0], 1'b0};
          w_exp_nxt  = r_exp - EXP_ONE;
        end
      end
      ROUND: begin
        if (w_rnd_exp >= EXP_MAX) begin
          w_float_nxt = N_float'({r_sign, {N_exp{1'b1}}, {N_mant{1'b0}}});
          w_ovf_nxt   = 1'b1;
        end else begin
          w_float_nxt = N_float'({r_sign, w_rnd_exp[N_exp-1:0], w_rnd_frac});
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_float     <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_exp       <= w_exp_nxt;
      r_mant      <= w_mant_nxt;
      r_float     <= w_float_nxt;
      r_ovf       <= w_ovf_nxt;
      r_udf       <= w_udf_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_norm_round.sv
// Self-checking bench for norm_round (single precision) with an expectation queue.
module tb_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sum_sign;
  logic [7:0]  sum_exp;
  logic [27:0] sum_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_R;
  logic        overflow;
  logic        underflow;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    string       name;
    logic [31:0] f;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] f;
    logic        o;
    logic        u;
    int          lat;
  } vec_t;

  exp_t sb[$];

  norm_round #(.N_float(32), .N_exp(8), .N_mant(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_sign(sum_sign), .sum_exp(sum_exp), .sum_mant(sum_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .float_R(float_R), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one raw sum; returns #1 after the accepting edge.
  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                      output bit ok);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    ok = in_ready;
    sum_sign = s; sum_exp = e; sum_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts cycles after the accepting edge, -1 on timeout.
  task automatic capture(output logic [31:0] f, output logic o, output logic u,
                         output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    f = float_R; o = overflow; u = underflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sum_sign = 1'b0; sum_exp = '0; sum_mant = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_chk++; if (float_R !== 32'h0) begin n_err++; $display("FAIL reset_float got=%h want=00000000", float_R); end
    n_chk++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b%b want=00", overflow, underflow); end
  endtask

  task automatic test_vectors();
    vec_t v[12];
    exp_t x;
    logic [31:0] f; logic o, u; int lat; bit ok;
    v[0]  = '{"carry_norm",   1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3};
    v[1]  = '{"cancel",       1'b0, 8'd130, 28'h0800000, 32'h3F800000, 1'b0, 1'b0, 6};
    v[2]  = '{"tie_round_up", 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 3};
    v[3]  = '{"tie_even",     1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3};
    v[4]  = '{"tie_odd_up",   1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3};
    v[5]  = '{"below_half",   1'b0, 8'd127, 28'h4000003, 32'h3F800000, 1'b0, 1'b0, 3};
    v[6]  = '{"carry_grs",    1'b0, 8'd100, 28'hC00000C, 32'h32C00001, 1'b0, 1'b0, 3};
    v[7]  = '{"overflow",     1'b1, 8'd254, 28'h8000000, 32'hFF800000, 1'b1, 1'b0, 3};
    v[8]  = '{"round_ovf",    1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 3};
    v[9]  = '{"zero",         1'b1, 8'd50,  28'h0000000, 32'h00000000, 1'b0, 1'b0, 2};
    v[10] = '{"uflow_neg",    1'b1, 8'd1,   28'h0000008, 32'h80000000, 1'b0, 1'b1, 2};
    v[11] = '{"uflow_shift",  1'b0, 8'd3,   28'h0000008, 32'h00000000, 1'b0, 1'b1, 4};
    for (int i = 0; i < 12; i++) begin
      sb.push_back('{v[i].name, v[i].f, v[i].o, v[i].u, v[i].lat});
      send(v[i].s, v[i].e, v[i].m, ok);
      capture(f, o, u, lat);
      x = sb.pop_front();
      n_chk++; if (lat !== x.lat) begin n_err++; $display("FAIL %s_latency got=%0d want=%0d", x.name, lat, x.lat); end
      n_chk++; if (f !== x.f) begin n_err++; $display("FAIL %s_float got=%h want=%h", x.name, f, x.f); end
      n_chk++; if ({o, u} !== {x.o, x.u}) begin n_err++; $display("FAIL %s_flags got=%b%b want=%b%b", x.name, o, u, x.o, x.u); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t x;
    logic [31:0] f; logic o, u; int lat; bit ok;
    out_ready = 1'b0;
    sb.push_back('{"bp", 32'h3F800002, 1'b0, 1'b0, 3});
    send(1'b0, 8'd127, 28'h400000C, ok);
    capture(f, o, u, lat);
    x = sb.pop_front();
    n_chk++; if (f !== x.f) begin n_err++; $display("FAIL bp_float got=%h want=%h", f, x.f); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++; if ({out_valid, in_ready, float_R} !== {1'b1, 1'b0, x.f})
        begin n_err++; $display("FAIL bp_hold_%0d got=v%b r%b %h want=v1 r0 %h", i, out_valid, in_ready, float_R, x.f); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release got=v%b r%b want=v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int seen = 0; bit ok;
    send(1'b0, 8'd130, 28'h0800000, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL rst_mid_idle got=r%b v%b want=r1 v0", in_ready, out_valid); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_no_output got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [31:0] f; logic o, u; int lat; bit ok;
    sb.push_back('{"b2b_a", 32'hBF800000, 1'b0, 1'b0, 3});
    sb.push_back('{"b2b_b", 32'h40400000, 1'b0, 1'b0, 3});
    send(1'b1, 8'd127, 28'h4000000, ok);
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy got=%b want=0", in_ready); end
    capture(f, o, u, lat);
    x = sb.pop_front();
    n_chk++; if ({f, lat} !== {x.f, x.lat}) begin n_err++; $display("FAIL %s got=%h/%0d want=%h/%0d", x.name, f, lat, x.f, x.lat); end
    @(posedge clk); #1;
    // exp 128, hidden 1, fraction MSB set -> 3.0
    send(1'b0, 8'd128, 28'h6000000, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b want=1", ok); end
    capture(f, o, u, lat);
    x = sb.pop_front();
    n_chk++; if ({f, lat} !== {x.f, x.lat}) begin n_err++; $display("FAIL %s got=%h/%0d want=%h/%0d", x.name, f, lat, x.f, x.lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/norm_round.md
NORM_ROUND -- requirements
Module: norm_round

Interface
REQ-001 Parameters SHALL be: N_float, default 32, total float width; N_exp, default 8, exponent width; N_mant, default 23, stored fraction width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  raw sum present.
- in_ready  out  1  block can accept a raw sum.
- sum_sign  in  1  sign of raw sum.
- sum_exp  in  N_exp  biased exponent of the larger operand.
- sum_mant  in  N_mant+5  raw magnitude, bit order MSB to LSB:
  - [N_mant+4] carry.
  - [N_mant+3] hidden bit.
  - [N_mant+2:3] fraction.
  - [2] guard.
  - [1] round.
  - [0] sticky.
- out_valid  out  1  packed result present.
- out_ready  in  1  consumer accepts result.
- float_R  out  N_float  packed IEEE-754 result: {sign, exp, fraction}.
- overflow  out  1  result saturated to infinity; valid with out_valid.
- underflow  out  1  result flushed to zero; valid with out_valid.

Function
REQ-003 The FSM SHALL have four states: IDLE, NORM, ROUND, DONE.
REQ-004 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 Input is accepted when in_valid and in_ready are both 1 at a clock edge.
- On acceptance: sign, exponent and mantissa SHALL be registered and the FSM SHALL go to NORM.
REQ-006 Internal exponent arithmetic SHALL use N_exp+2 bits, so that no intermediate value wraps.
REQ-007 NORM SHALL perform exactly one action per cycle, in this priority order:
- (a) mantissa == 0: result +0 (sign 0), go to DONE.
- (b) carry == 1: shift right 1, OR the shifted-out bit into sticky, exp+1, go to ROUND.
- (c) hidden == 1: go to ROUND.
- (d) hidden == 0 and exp == 1: flush to signed zero {sign, 0...}, underflow=1, go to DONE.
- (e) otherwise: shift left 1 with zero fill, exp-1, stay in NORM.
REQ-008 ROUND SHALL apply round-to-nearest-even: increment the fraction when guard & (round | sticky | fraction LSB).
REQ-009 If the increment carries into the carry position, ROUND SHALL shift right 1 and exp+1 in the same cycle.
REQ-010 After rounding, if exp >= 2^N_exp-1, the result SHALL be {sign, all-ones, 0} with overflow=1.
- Otherwise the result SHALL be {sign, exp[N_exp-1:0], fraction}.
- ROUND SHALL then go to DONE.
REQ-011 In DONE, out_valid SHALL be 1 and float_R, overflow and underflow SHALL hold stable.
- They SHALL remain stable until out_ready is 1 at an edge; the FSM then goes to IDLE.
REQ-012 out_valid SHALL be 0 in every state except DONE; no new input is accepted in DONE.
REQ-013 Latency (accepting edge to first out_valid cycle) SHALL be:
- 3 cycles for a normalized input or a carry input.
- 3+k cycles for k left shifts.
- 2 cycles for a zero input.
- 2+k cycles for an underflow flush reached after k left shifts.
REQ-014 Throughput SHALL be one result per transaction; there is no overlap between transactions.

Reset
REQ-015 While rst_n is 0 at a clock edge, the FSM SHALL go to IDLE regardless of current state, including mid-NORM or DONE.
- After that edge: in_ready=1, out_valid=0, float_R=0, overflow=0, underflow=0.
REQ-016 A transaction interrupted by reset SHALL be discarded, with no output produced for it.

Verification (N_float=32; "x" = latency in cycles after the accepting edge)
REQ-017 Carry normalize: sign 0, exp 127, carry=1, hidden=0, fraction 0, GRS=000.
- Required: float_R=0x40000000, overflow=0, underflow=0, x=3.
REQ-018 Cancellation: exp 130, hidden=0, fraction MSB-first 0010...0 (leading one 3 places below hidden).
- Required: float_R=0x3F800000, x=6.
REQ-019 Rounding ties:
- Hidden 1, fraction all ones, GRS=100, exp 127: required 0x40000000 (round-up carry).
- Fraction 0, GRS=100, exp 127: required 0x3F800000 (tie to even, no increment).
REQ-020 Overflow: sign 1, exp 254, carry=1.
- Required: float_R=0xFF800000, overflow=1.
REQ-021 Zero and underflow:
- Zero mantissa: required 0x00000000, x=2.
- exp 1, hidden 0, fraction nonzero: required float_R=0x00000000 or 0x80000000 per sign, underflow=1.
REQ-022 Backpressure and reset:
- Hold out_ready=0 for 5 cycles in DONE: float_R stays stable and in_ready=0 throughout.
- Assert rst_n=0 for one cycle during NORM: the next cycle shows IDLE, out_valid=0, and no result is emitted.
